// File: rtl/tdc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdc_pkg
// Description : Shared types, widths and limits for the TDC measurement
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package tdc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_ACCUM   = 3'd4,
        ST_DONE    = 3'd5
    } tdc_state_t;

    // Largest supported averaging exponent (8 samples).
    localparam int MAX_AVG_LOG2 = 3;

    function automatic int tdc_cw(input int taps);
        return $clog2(taps + 1);
    endfunction

    function automatic int tdc_acc_w(input int taps);
        return tdc_cw(taps) + MAX_AVG_LOG2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : tdc_sequencer_if
// Description : Request/result and delay-line bundle between the pin logic
//               (master) and the TDC sequencer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface tdc_sequencer_if #(
    parameter int TAPS = 32
);
    import tdc_pkg::*;

    localparam int CW = tdc_cw(TAPS);

    logic                    start;
    logic [1:0]              avg_log2;
    logic [TAPS-1:0]         taps_in;
    logic                    launch;
    logic                    capture;
    logic                    busy;
    logic                    done;
    logic [CW-1:0]           result;
    logic                    err;

    modport master (
        output start, avg_log2, taps_in,
        input  launch, capture, busy, done, result, err
    );

    modport slave (
        input  start, avg_log2, taps_in,
        output launch, capture, busy, done, result, err
    );

endinterface
`default_nettype wire

// File: rtl/tdc_therm_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tdc_therm_encoder
// Description : Thermometer-to-binary priority encoder with overflow and
//               bubble detection for the captured delay-line taps.
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_therm_encoder
    import tdc_pkg::*;
#(
    parameter int TAPS = 32,
    localparam int CW  = tdc_cw(TAPS)
) (
    input  logic [TAPS-1:0] taps_i,
    output logic [CW-1:0]   code_o,
    output logic            overflow_o,
    output logic            bubble_o
);

    logic [TAPS-1:0] therm;

    always_comb begin
        code_o     = CW'(TAPS);
        overflow_o = &taps_i;
        // Scanning downward lets the lowest zero win.
        for (int i = TAPS - 1; i >= 0; i--) begin
            if (!taps_i[i]) begin
                code_o = CW'(i);
            end
        end
        therm = '0;
        for (int i = 0; i < TAPS; i++) begin
            therm[i] = (CW'(i) < code_o);
        end
        // A clean code is exactly the ones below the lowest zero.
        bubble_o = (taps_i != therm);
    end

endmodule
`default_nettype wire

// File: rtl/tdc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tdc_sequencer
// Description : Launch/settle/capture sequencer that averages 1..8 TDC
//               samples and reports the mean tap count with a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_sequencer
    import tdc_pkg::*;
#(
    parameter int TAPS       = 32,
    parameter int SETTLE_CYC = 2
) (
    input  logic           clk,
    input  logic           rst,
    tdc_sequencer_if.slave bus
);

    localparam int CW    = tdc_cw(TAPS);
    localparam int ACC_W = tdc_acc_w(TAPS);
    localparam int IDX_W = MAX_AVG_LOG2;
    localparam int SW    = $clog2(SETTLE_CYC + 1);

    tdc_state_t       state_q;
    logic [SW-1:0]    settle_q;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       avg_q;
    logic [ACC_W-1:0] acc_q;
    logic [TAPS-1:0]  taps_q;
    logic [CW-1:0]    result_q;
    logic             launch_q;
    logic             capture_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic [CW-1:0]    enc_code;
    logic             enc_ovf;
    logic             enc_bub;
    logic [ACC_W-1:0] acc_d;
    logic [CW-1:0]    result_d;
    logic [IDX_W-1:0] last_idx;

    tdc_therm_encoder #(
        .TAPS (TAPS)
    ) u_enc (
        .taps_i     (taps_q),
        .code_o     (enc_code),
        .overflow_o (enc_ovf),
        .bubble_o   (enc_bub)
    );

    assign acc_d    = acc_q + ACC_W'(enc_code);
    assign result_d = CW'(acc_d >> avg_q);
    assign last_idx = IDX_W'((1 << avg_q) - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            settle_q  <= '0;
            idx_q     <= '0;
            avg_q     <= '0;
            acc_q     <= '0;
            taps_q    <= '0;
            result_q  <= '0;
            launch_q  <= 1'b0;
            capture_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            launch_q  <= 1'b0;
            capture_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q  <= ST_LAUNCH;
                        avg_q    <= bus.avg_log2;
                        acc_q    <= '0;
                        idx_q    <= '0;
                        err_q    <= 1'b0;
                        launch_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    state_q  <= ST_SETTLE;
                    settle_q <= SW'(SETTLE_CYC - 1);
                end
                ST_SETTLE: begin
                    if (settle_q == '0) begin
                        state_q   <= ST_CAPTURE;
                        capture_q <= 1'b1;
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    taps_q  <= bus.taps_in;
                    state_q <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    acc_q <= acc_d;
                    err_q <= err_q | enc_ovf | enc_bub;
                    if (idx_q == last_idx) begin
                        state_q  <= ST_DONE;
                        done_q   <= 1'b1;
                        result_q <= result_d;
                    end else begin
                        idx_q    <= idx_q + 1'b1;
                        state_q  <= ST_LAUNCH;
                        launch_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.launch  = launch_q;
    assign bus.capture = capture_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.err     = err_q;

endmodule
`default_nettype wire
